// File: rtl/seq_signed_div_pkg.sv
// Shared constants and FSM state type for the sequential signed divider.
// The widths here are the defaults that the top-level module parameters start from.
package seq_signed_div_pkg;

   localparam int DW_DEF = 8;
   localparam int VW_DEF = 4;
   localparam int CNT_W  = $clog2(DW_DEF) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/seq_signed_div_sub.sv
// Ripple trial subtractor for the restoring divider, built from the dataflow full adder.
// The difference is x + ~y + 1, so borrow is the inverted carry out.
module fa_df (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

module div_sub_stage #(
   parameter int W = 5
) (
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   output logic [W-1:0] diff_o,
   output logic         borrow_o
);

   logic [W:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < W; i++) begin : g_bit
      fa_df u_fa (
         .a_i  (x_i[i]),
         .b_i  (~y_i[i]),
         .ci_i (carry[i]),
         .s_o  (diff_o[i]),
         .co_o (carry[i+1])
      );
   end

   assign borrow_o = ~carry[W];

endmodule

// File: rtl/seq_signed_div.sv
// Sequential signed divider: restoring division on magnitudes over DW cycles,
// followed by a one-cycle sign fix. Handshake: start is sampled only while IDLE, busy covers the whole operation, and done pulses for one cycle afterwards.
module seq_signed_div
   import seq_signed_div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] a,
   input  logic [VW-1:0] b,
   output logic [DW-1:0] q,
   output logic [VW-1:0] r,
   output logic          busy,
   output logic          done,
   output logic          dbz,
   output logic          ovf,
   output state_e        dbg_state
);

   localparam logic [DW:0]      A_ONE    = {{DW{1'b0}}, 1'b1};
   localparam logic [VW:0]      B_ONE    = {{VW{1'b0}}, 1'b1};
   localparam logic [DW-1:0]    Q_ONE    = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [VW-1:0]    R_ONE    = {{(VW-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]     dvd_q, dvd_d;
   logic [DW-1:0]     quo_q, quo_d;
   logic [VW-1:0]     rem_q, rem_d;
   logic [VW:0]       bmag_q, bmag_d;
   logic              asign_q, asign_d;
   logic              qsign_q, qsign_d;
   logic [DW-1:0]     q_q, q_d;
   logic [VW-1:0]     r_q, r_d;
   logic              done_q, done_d;
   logic              dbz_q, dbz_d;
   logic              ovf_q, ovf_d;

   logic [DW:0]       a_ext, amag;
   logic [VW:0]       b_ext, bmag;
   logic [VW:0]       shifted, diff;
   logic              borrow;
   logic              diff_msb_unused;
   logic [DW-1:0]     q_fix;
   logic [VW-1:0]     r_fix;

   // 128 and 8 need one extra bit as magnitudes, hence the sign-extended negation.
   assign a_ext = {a[DW-1], a};
   assign amag  = a[DW-1] ? (~a_ext + A_ONE) : a_ext;
   assign b_ext = {b[VW-1], b};
   assign bmag  = b[VW-1] ? (~b_ext + B_ONE) : b_ext;

   assign shifted = {rem_q, dvd_q[DW-1]};

   div_sub_stage #(
      .W (VW + 1)
   ) u_sub (
      .x_i      (shifted),
      .y_i      (bmag_q),
      .diff_o   (diff),
      .borrow_o (borrow)
   );

   // A successful trial subtract leaves a value below |b|, so the top difference bit carries nothing.
   assign diff_msb_unused = diff[VW];

   assign q_fix = qsign_q ? (~quo_q + Q_ONE) : quo_q;
   assign r_fix = asign_q ? (~rem_q + R_ONE) : rem_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      bmag_d  = bmag_q;
      asign_d = asign_q;
      qsign_d = qsign_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CALC;
               cnt_d   = '0;
               dvd_d   = amag[DW-1:0];
               rem_d   = {{(VW-1){1'b0}}, amag[DW]};
               quo_d   = '0;
               bmag_d  = bmag;
               asign_d = a[DW-1];
               qsign_d = a[DW-1] ^ b[VW-1];
            end
         end
         ST_CALC: begin
            dvd_d = {dvd_q[DW-2:0], 1'b0};
            quo_d = {quo_q[DW-2:0], ~borrow};
            rem_d = borrow ? shifted[VW-1:0] : diff[VW-1:0];
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (bmag_q == '0) begin
               q_d   = '0;
               r_d   = '0;
               dbz_d = 1'b1;
               ovf_d = 1'b0;
            end else begin
               // A positive quotient with its MSB set cannot be represented.
               q_d   = q_fix;
               r_d   = r_fix;
               dbz_d = 1'b0;
               ovf_d = ~qsign_q & quo_q[DW-1];
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         bmag_q  <= '0;
         asign_q <= 1'b0;
         qsign_q <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         bmag_q  <= bmag_d;
         asign_q <= asign_d;
         qsign_q <= qsign_d;
         q_q     <= q_d;
         r_q     <= r_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign q         = q_q;
   assign r         = r_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign dbz       = dbz_q;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_signed_div.sv
// Bench for seq_signed_div: directed corner cases, then every (a, b) pair
// with random idle gaps, each checked against a truncating-division model.
module tb_seq_signed_div;
   import seq_signed_div_pkg::*;

   localparam int DW = 8;
   localparam int VW = 4;
   localparam int RW = DW + VW + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] a;
   logic [VW-1:0] b;
   logic [DW-1:0] q;
   logic [VW-1:0] r;
   logic          busy, done, dbz, ovf;
   state_e        dbg_state;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int n_done = 0;
   logic [RW-1:0] exp_q[$];
   int            start_cyc_q[$];

   seq_signed_div #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .q         (q),
      .r         (r),
      .busy      (busy),
      .done      (done),
      .dbz       (dbz),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   // clock / cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [RW-1:0] pk(input logic [DW-1:0] qv, input logic [VW-1:0] rv,
                                        input logic dz, input logic ov);
      return {qv, rv, dz, ov};
   endfunction

   function automatic logic [RW-1:0] model(input int ai, input int bi);
      int qi, ri;
      logic [DW-1:0] qv;
      logic [VW-1:0] rv;
      if (bi == 0) return pk('0, '0, 1'b1, 1'b0);
      if (ai == -(1 << (DW - 1)) && bi == -1) return pk(DW'(1 << (DW - 1)), '0, 1'b0, 1'b1);
      qi = ai / bi;
      ri = ai % bi;
      qv = qi[DW-1:0];
      rv = ri[VW-1:0];
      return pk(qv, rv, 1'b0, 1'b0);
   endfunction

   // scoreboard: every done pops one expected result and its start cycle
   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (exp_q.size() == 0) begin
            chk("done_without_request", 32'(exp_q.size()), 32'd1);
         end else begin
            logic [RW-1:0] e;
            int s;
            e = exp_q.pop_front();
            s = start_cyc_q.pop_front();
            chk("result_q_r_dbz_ovf", 32'({q, r, dbz, ovf}), 32'(e));
            chk("latency", 32'(cyc - s), 32'd10);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic issue(input logic [DW-1:0] av, input logic [VW-1:0] bv, input logic [RW-1:0] e);
      wait_idle();
      a = av;
      b = bv;
      start = 1'b1;
      exp_q.push_back(e);
      start_cyc_q.push_back(cyc);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({q, r, busy, done, dbz, ovf}), 32'd0);
      chk("reset_fsm", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      @(posedge clk); #1;

      // 100 / 7
      issue(DW'(100), VW'(7), pk(8'h0E, 4'h2, 1'b0, 1'b0));
      chk("busy_after_start", 32'(busy), 32'd1);
      wait_drain();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("q_held", 32'(q), 32'h0E);

      // signed cases, issued back to back in each done cycle
      issue(DW'(-100), VW'(7), pk(8'hF2, 4'hE, 1'b0, 1'b0));
      issue(DW'(-128), VW'(-8), pk(8'h10, 4'h0, 1'b0, 1'b0));
      issue(DW'(-128), VW'(-1), pk(8'h80, 4'h0, 1'b0, 1'b1));
      issue(DW'(37), VW'(0), pk(8'h00, 4'h0, 1'b1, 1'b0));
      wait_drain();

      // start during CALC is ignored
      d0 = n_done;
      issue(DW'(50), VW'(3), pk(8'h10, 4'h2, 1'b0, 1'b0));
      repeat (3) @(posedge clk);
      #1;
      a = DW'(1);
      b = VW'(1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = '0;
      b = '0;
      wait_drain();
      repeat (12) @(posedge clk);
      #1;
      chk("busy_single_done", 32'(n_done - d0), 32'd1);

      // reset on the 5th CALC cycle aborts the operation
      a = DW'(100);
      b = VW'(7);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("calc_before_abort", 32'(dbg_state), 32'(ST_CALC));
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_fsm", 32'(dbg_state), 32'(ST_IDLE));
      chk("abort_outputs", 32'({q, r, busy, done, dbz, ovf}), 32'd0);
      rst = 1'b0;
      d0 = n_done;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(n_done - d0), 32'd0);
      issue(DW'(9), VW'(-2), pk(8'hFC, 4'h1, 1'b0, 1'b0));
      wait_drain();

      // full operand sweep with random idle gaps
      for (int ai = -(1 << (DW - 1)); ai < (1 << (DW - 1)); ai++) begin
         for (int bi = -(1 << (VW - 1)); bi < (1 << (VW - 1)); bi++) begin
            if ($urandom_range(0, 3) == 0) begin
               wait_idle();
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
            issue(ai[DW-1:0], bi[VW-1:0], model(ai, bi));
         end
      end
      wait_drain();
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
